// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage control, program-load and IF/ID output bundle
//
// Purpose: groups every fetch_unit signal except clock and reset.
//   master : pipeline control / loader side. It drives Stall, PCSrc, BranchTarget
//            and WriteEnable/WriteAddr/WriteData, and it observes the outputs.
//   slave  : fetch_unit side. It drives PC, Instr, InstrPC, PCPlus4, Valid and
//            FetchCount.
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  Stall;
  logic                  PCSrc;
  logic [ADDR_WIDTH-1:0] BranchTarget;
  logic                  WriteEnable;
  logic [ADDR_WIDTH-1:0] WriteAddr;
  logic [DATA_WIDTH-1:0] WriteData;

  logic [ADDR_WIDTH-1:0] PC;
  logic [DATA_WIDTH-1:0] Instr;
  logic [ADDR_WIDTH-1:0] InstrPC;
  logic [ADDR_WIDTH-1:0] PCPlus4;
  logic                  Valid;
  logic [CNT_WIDTH-1:0]  FetchCount;

  modport master (
    output Stall, PCSrc, BranchTarget, WriteEnable, WriteAddr, WriteData,
    input  PC, Instr, InstrPC, PCPlus4, Valid, FetchCount
  );

  modport slave (
    input  Stall, PCSrc, BranchTarget, WriteEnable, WriteAddr, WriteData,
    output PC, Instr, InstrPC, PCPlus4, Valid, FetchCount
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with stall, redirect/flush and fetch counter
//
// Purpose: holds the PC and a word-addressed instruction memory with synchronous
// read. It presents registered IF/ID outputs.
// Ports:
//   Clk    : clock. All state changes on the rising edge.
//   Reset  : synchronous, active-high. It takes priority over everything else.
//   bus    : fetch_unit_if.slave. Its inputs are Stall, PCSrc, BranchTarget and
//            WriteEnable/WriteAddr/WriteData. Its outputs are PC, Instr, InstrPC,
//            PCPlus4, Valid and FetchCount.
// Priority per edge: Reset > PCSrc > Stall > normal fetch. The write port is
// independent of Stall and PCSrc and is blocked only by Reset.
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH_LOG2 = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  fetch_unit_if.slave bus
);

  localparam int                    DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  // Edge operation, decoded once so that the register and memory processes
  // agree on what happens at this edge.
  typedef enum logic [1:0] {
    OP_RESET,
    OP_REDIRECT,
    OP_HOLD,
    OP_FETCH
  } op_e;

  op_e op;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic [ADDR_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
  logic                  valid_q, valid_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0] instr_q;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic                  mem_we;

  // Bits [1:0] are ignored. Address bits above the memory range alias onto
  // the same words.
  assign rd_idx = pc_q[DEPTH_LOG2+1:2];
  assign wr_idx = bus.WriteAddr[DEPTH_LOG2+1:2];
  assign mem_we = bus.WriteEnable && !Reset;

  wire unused_waddr_bits = ^{bus.WriteAddr[ADDR_WIDTH-1:DEPTH_LOG2+2],
                             bus.WriteAddr[1:0]};

  always_comb begin
    op = OP_FETCH;
    if (Reset) begin
      op = OP_RESET;
    end else if (bus.PCSrc) begin
      op = OP_REDIRECT;
    end else if (bus.Stall) begin
      op = OP_HOLD;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    instr_pc_d = instr_pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    count_d    = count_q;
    case (op)
      OP_RESET: begin
        pc_d       = RESET_PC;
        instr_pc_d = '0;
        pc_plus4_d = PC_STEP;
        valid_d    = 1'b0;
        count_d    = '0;
      end
      OP_REDIRECT: begin
        // The word being read this cycle is wrong-path. It is dropped by
        // clearing Valid, and the Instr-side registers are left as they are.
        pc_d    = bus.BranchTarget;
        valid_d = 1'b0;
      end
      OP_HOLD: begin
      end
      OP_FETCH: begin
        pc_d       = pc_q + PC_STEP;
        instr_pc_d = pc_q;
        pc_plus4_d = pc_q + PC_STEP;
        valid_d    = 1'b1;
        // Saturate instead of wrapping.
        count_d    = (count_q == '1) ? count_q : count_q + CNT_WIDTH'(1);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    pc_q       <= pc_d;
    instr_pc_q <= instr_pc_d;
    pc_plus4_q <= pc_plus4_d;
    valid_q    <= valid_d;
    count_q    <= count_d;
  end

  // Program-load port. The array itself is never reset.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[wr_idx] <= bus.WriteData;
    end
  end

  // Synchronous read straight into the Instr register. A write to the same
  // word at this edge is not seen until a later fetch.
  always_ff @(posedge Clk) begin
    if (op == OP_RESET) begin
      instr_q <= '0;
    end else if (op == OP_FETCH) begin
      instr_q <= mem[rd_idx];
    end
  end

  assign bus.PC         = pc_q;
  assign bus.Instr      = instr_q;
  assign bus.InstrPC    = instr_pc_q;
  assign bus.PCPlus4    = pc_plus4_q;
  assign bus.Valid      = valid_q;
  assign bus.FetchCount = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(16)) if0 ();
  fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(4))  if1 ();

  // The second instance has a different reset PC and a narrow counter.
  // It receives the same stimulus as the first.
  assign if1.Stall        = if0.Stall;
  assign if1.PCSrc        = if0.PCSrc;
  assign if1.BranchTarget = if0.BranchTarget;
  assign if1.WriteEnable  = if0.WriteEnable;
  assign if1.WriteAddr    = if0.WriteAddr;
  assign if1.WriteData    = if0.WriteData;

  fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(8),
               .RESET_PC(32'h0), .CNT_WIDTH(16)) dut0 (
    .Clk(Clk), .Reset(Reset), .bus(if0.slave));

  fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(8),
               .RESET_PC(32'h100), .CNT_WIDTH(4)) dut1 (
    .Clk(Clk), .Reset(Reset), .bus(if1.slave));

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural reference for dut0.
  logic [31:0] m_mem [256];
  logic [31:0] m_pc, m_instr, m_ipc, m_p4;
  logic        m_valid;
  logic        m_known;
  int          m_cnt;

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE0000 | 32'(i);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic st, input logic ps,
                      input logic [31:0] tg, input logic we,
                      input logic [31:0] wa, input logic [31:0] wd);
    Reset            = rst;
    if0.Stall        = st;
    if0.PCSrc        = ps;
    if0.BranchTarget = tg;
    if0.WriteEnable  = we;
    if0.WriteAddr    = wa;
    if0.WriteData    = wd;
    if (rst) begin
      m_pc = 32'h0; m_instr = 0; m_ipc = 0; m_p4 = 32'h4;
      m_valid = 0; m_known = 1; m_cnt = 0;
    end else begin
      if (ps) begin
        m_pc = tg; m_valid = 0; m_known = 0;
      end else if (!st) begin
        m_instr = m_mem[widx(m_pc)];
        m_ipc = m_pc;
        m_p4 = m_pc + 32'd4;
        m_valid = 1; m_known = 1;
        if (m_cnt < 65535) m_cnt++;
        m_pc = m_pc + 32'd4;
      end
      if (we) m_mem[widx(wa)] = wd;
    end
    @(posedge Clk);
    #1;
    chk("model_pc", if0.PC, m_pc);
    chk("model_valid", 32'(if0.Valid), 32'(m_valid));
    chk("model_cnt", 32'(if0.FetchCount), 32'(m_cnt));
    if (m_known) begin
      chk("model_instr", if0.Instr, m_instr);
      chk("model_ipc", if0.InstrPC, m_ipc);
      chk("model_p4", if0.PCPlus4, m_p4);
    end
    chk("sat_valid", 32'(if1.Valid), 32'(m_valid));
    chk("sat_cnt", 32'(if1.FetchCount), 32'((m_cnt > 15) ? 15 : m_cnt));
  endtask

  typedef struct {
    logic        st;
    logic        ps;
    logic [31:0] tg;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [31:0] e_pc;
    logic        e_v;
    logic [31:0] e_ipc;
    logic [31:0] e_instr;
    int          e_cnt;
  } vec_t;

  vec_t tbl [16];

  initial begin
    tbl[0]  = '{0, 0, 32'h0,  0, 32'h0,   32'h0,        32'h04, 1, 32'h00, 32'h02324020, 1};
    tbl[1]  = '{0, 0, 32'h0,  0, 32'h0,   32'h0,        32'h08, 1, 32'h04, 32'h014B6822, 2};
    tbl[2]  = '{1, 0, 32'h0,  0, 32'h0,   32'h0,        32'h08, 1, 32'h04, 32'h014B6822, 2};
    tbl[3]  = '{1, 0, 32'h0,  0, 32'h0,   32'h0,        32'h08, 1, 32'h04, 32'h014B6822, 2};
    tbl[4]  = '{1, 0, 32'h0,  0, 32'h0,   32'h0,        32'h08, 1, 32'h04, 32'h014B6822, 2};
    tbl[5]  = '{0, 0, 32'h0,  0, 32'h0,   32'h0,        32'h0C, 1, 32'h08, 32'hAAAA0000, 3};
    tbl[6]  = '{0, 1, 32'h40, 0, 32'h0,   32'h0,        32'h40, 0, 32'h0,  32'h0,        3};
    tbl[7]  = '{0, 0, 32'h0,  0, 32'h0,   32'h0,        32'h44, 1, 32'h40, 32'hC0DE0010, 4};
    tbl[8]  = '{0, 0, 32'h0,  0, 32'h0,   32'h0,        32'h48, 1, 32'h44, 32'hC0DE0011, 5};
    tbl[9]  = '{1, 1, 32'h1C, 0, 32'h0,   32'h0,        32'h1C, 0, 32'h0,  32'h0,        5};
    tbl[10] = '{0, 0, 32'h0,  0, 32'h0,   32'h0,        32'h20, 1, 32'h1C, 32'hC0DE0007, 6};
    tbl[11] = '{0, 0, 32'h0,  1, 32'h20,  32'hDEADBEEF, 32'h24, 1, 32'h20, 32'hC0DE0008, 7};
    tbl[12] = '{0, 1, 32'h20, 0, 32'h0,   32'h0,        32'h20, 0, 32'h0,  32'h0,        7};
    tbl[13] = '{0, 0, 32'h0,  0, 32'h0,   32'h0,        32'h24, 1, 32'h20, 32'hDEADBEEF, 8};
    tbl[14] = '{0, 1, 32'h20, 1, 32'h422, 32'h12345678, 32'h20, 0, 32'h0,  32'h0,        8};
    tbl[15] = '{0, 0, 32'h0,  0, 32'h0,   32'h0,        32'h24, 1, 32'h20, 32'h12345678, 9};

    for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;

    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // Load the program while stalled. The reset state is held meanwhile.
    for (int i = 0; i < 256; i++) begin
      logic [31:0] w;
      case (i)
        0:       w = 32'h02324020;
        1:       w = 32'h014B6822;
        2:       w = 32'hAAAA0000;
        3:       w = 32'hBBBB0000;
        default: w = pat(i);
      endcase
      step(0, 1, 0, 0, 1, 32'(i * 4), w);
    end
    chk("rst_pc", if0.PC, 32'h0);
    chk("rst_instr", if0.Instr, 32'h0);
    chk("rst_ipc", if0.InstrPC, 32'h0);
    chk("rst_p4", if0.PCPlus4, 32'h4);
    chk("rst_valid", 32'(if0.Valid), 32'h0);
    chk("rst_cnt", 32'(if0.FetchCount), 32'h0);
    chk("rst_pc_alt", if1.PC, 32'h100);

    for (int i = 0; i < 16; i++) begin
      step(0, tbl[i].st, tbl[i].ps, tbl[i].tg, tbl[i].we, tbl[i].wa, tbl[i].wd);
      chk($sformatf("tbl%0d_pc", i), if0.PC, tbl[i].e_pc);
      chk($sformatf("tbl%0d_valid", i), 32'(if0.Valid), 32'(tbl[i].e_v));
      chk($sformatf("tbl%0d_cnt", i), 32'(if0.FetchCount), 32'(tbl[i].e_cnt));
      if (tbl[i].e_v) begin
        chk($sformatf("tbl%0d_ipc", i), if0.InstrPC, tbl[i].e_ipc);
        chk($sformatf("tbl%0d_instr", i), if0.Instr, tbl[i].e_instr);
        chk($sformatf("tbl%0d_p4", i), if0.PCPlus4, tbl[i].e_ipc + 32'd4);
      end
    end

    // PC + 4 wraps at the top of the address space.
    step(0, 0, 1, 32'hFFFFFFFC, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("wrap_ipc", if0.InstrPC, 32'hFFFFFFFC);
    chk("wrap_p4", if0.PCPlus4, 32'h0);
    chk("wrap_pc", if0.PC, 32'h0);
    chk("wrap_instr", if0.Instr, 32'hC0DE00FF);

    for (int i = 0; i < 400; i++) begin
      logic        r, s, p, w;
      logic [31:0] t;
      r = ($urandom_range(0, 39) == 0);
      s = ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 7) == 0);
      w = ($urandom_range(0, 2) == 0);
      t = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 : $urandom;
      step(r, s, p, t, w, $urandom, $urandom);
    end

    // Reset in the middle of a stream discards a pending redirect and a pending stall.
    step(0, 0, 1, 32'h2C, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("mid_pc", if0.PC, 32'h30);
    chk("mid_valid", 32'(if0.Valid), 32'h1);
    step(1, 1, 1, 32'h80, 0, 0, 0);
    chk("mrst_pc", if0.PC, 32'h0);
    chk("mrst_valid", 32'(if0.Valid), 32'h0);
    chk("mrst_cnt", 32'(if0.FetchCount), 32'h0);
    chk("mrst_pc_alt", if1.PC, 32'h100);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("restart_ipc", if0.InstrPC, 32'h0);
    chk("restart_valid", 32'(if0.Valid), 32'h1);
    chk("restart_ipc_alt", if1.InstrPC, 32'h100);
    chk("restart_instr_alt", if1.Instr, m_mem[64]);
    chk("restart_pc_alt", if1.PC, 32'h104);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
